// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-function ALU with registered result and NZCV flags.
// Single-cycle ops complete on the accept edge. Shifts step one bit per cycle.
// MUL is an iterative shift-add over WIDTH cycles. Result and flags are held
// in DONE until the consumer takes them.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       select,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   // The iteration counter must hold WIDTH itself for MUL.
   localparam int CW  = SHW + 1;

   typedef enum logic [3:0] {
      OP_OR   = 4'b0000,
      OP_AND  = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_NOT  = 4'b0100,
      OP_SHL  = 4'b0101,
      OP_SHR  = 4'b0110,
      OP_ZERO = 4'b0111,
      OP_SUB  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_SLT  = 4'b1010,
      OP_SLTU = 4'b1011,
      OP_MUL  = 4'b1100
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_e;

   state_e           state;
   op_e              op_q;
   logic [WIDTH-1:0] acc_q;     // shift operand, or running product for MUL
   logic [WIDTH-1:0] mcand_q;   // multiplicand, shifted left each MUL step
   logic [WIDTH-1:0] mplier_q;  // multiplier, consumed LSB first
   logic [CW-1:0]    cnt_q;     // iterations still to do in EXEC

   logic             accept;
   logic [SHW-1:0]   n_in;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] s_y;
   logic             s_c;
   logic             s_v;
   logic             go_exec;
   logic [WIDTH-1:0] step_y;
   logic             step_c;

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // Upper bits of b are ignored for the shift amount.
   assign n_in     = b[SHW-1:0];
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};

   // Result and flags for ops that finish on the accept edge; flags shifts/MUL for EXEC.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      s_y     = '0;
      s_c     = 1'b0;
      s_v     = 1'b0;
      go_exec = 1'b0;
      case (select)
         OP_OR:   s_y = a | b;
         OP_AND:  s_y = a & b;
         OP_ADD: begin
            s_y = sum_ext[WIDTH-1:0];
            s_c = sum_ext[WIDTH];
            s_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:  s_y = a ^ b;
         OP_NOT:  s_y = ~a;
         OP_SHL, OP_SHR, OP_SRA: begin
            // A zero-length shift passes a through with carry clear.
            s_y     = a;
            go_exec = (n_in != '0);
         end
         OP_SUB: begin
            s_y = diff_ext[WIDTH-1:0];
            s_c = ~diff_ext[WIDTH];
            s_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  s_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: s_y = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MUL:  go_exec = 1'b1;
         default: s_y = '0;
      endcase
   end

   // One EXEC iteration: a single-bit shift, or one shift-add multiply step.
   always_comb begin
      step_y = acc_q;
      step_c = 1'b0;
      case (op_q)
         OP_SHL: begin
            step_y = {acc_q[WIDTH-2:0], 1'b0};
            step_c = acc_q[WIDTH-1];
         end
         OP_SHR: begin
            step_y = {1'b0, acc_q[WIDTH-1:1]};
            step_c = acc_q[0];
         end
         OP_SRA: begin
            step_y = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            step_c = acc_q[0];
         end
         OP_MUL: step_y = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
         default: step_y = acc_q;
      endcase
   end

   // Control FSM with registered result, flags and out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset along with control so an aborted operation leaves no residue visible on y or the flags.
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_ZERO;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         y         <= '0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking assignments here; every register samples pre-edge values, so the order of statements cannot matter.
         op_q <= op_e'(select);
         if (go_exec) begin
            state     <= EXEC;
            out_valid <= 1'b0;
            if (select == OP_MUL) begin
               acc_q    <= '0;
               mcand_q  <= a;
               mplier_q <= b;
               cnt_q    <= CW'(WIDTH);
            end else begin
               acc_q <= a;
               cnt_q <= {1'b0, n_in};
            end
         end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= s_y;
            zero      <= (s_y == '0);
            neg       <= s_y[WIDTH-1];
            carry     <= s_c;
            ovf       <= s_v;
         end
      end else begin
         case (state)
            EXEC: begin
               acc_q    <= step_y;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  y         <= step_y;
                  zero      <= (step_y == '0);
                  neg       <= step_y[WIDTH-1];
                  carry     <= step_c;
                  ovf       <= 1'b0;
               end
            end
            DONE: begin
               // out_ready alone retires the result; with in_valid the accept branch above runs instead.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal cases plus randomized traffic, all checked
// against a cycle-level behavioural model of alu_seq at WIDTH=32.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  select;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        zero;
   logic        neg;
   logic        carry;
   logic        ovf;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic rdy_rand = 1'b0;
   logic rdy_dir  = 1'b1;

   alu_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .select    (select),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result, flags {zero,neg,carry,ovf} and accept-to-valid latency.
   function automatic void model(input logic [3:0] sel, input logic [31:0] ra,
                                 input logic [31:0] rb, output logic [31:0] r,
                                 output logic [3:0] f, output int lat);
      int         n;
      logic       c;
      logic       v;
      longint     sa;
      longint     sb;
      longint     sres;
      logic [63:0] wide;
      n   = int'(rb[4:0]);
      c   = 1'b0;
      v   = 1'b0;
      lat = 1;
      r   = '0;
      sa  = longint'($signed(ra));
      sb  = longint'($signed(rb));
      case (sel)
         4'd0: r = ra | rb;
         4'd1: r = ra & rb;
         4'd2: begin
            wide = {32'b0, ra} + {32'b0, rb};
            r    = wide[31:0];
            c    = wide[32];
            sres = sa + sb;
            v    = (sres != longint'($signed(r)));
         end
         4'd3: r = ra ^ rb;
         4'd4: r = ~ra;
         4'd5: begin
            wide = {32'b0, ra} << n;
            r    = wide[31:0];
            c    = wide[32];
            lat  = n + 1;
         end
         4'd6: begin
            r    = ra >> n;
            wide = {ra, 32'b0} >> n;
            c    = wide[31];
            lat  = n + 1;
         end
         4'd8: begin
            r    = ra - rb;
            c    = (ra >= rb);
            sres = sa - sb;
            v    = (sres != longint'($signed(r)));
         end
         4'd9: begin
            r    = $signed(ra) >>> n;
            wide = {ra, 32'b0} >> n;
            c    = wide[31];
            lat  = n + 1;
         end
         4'd10: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd11: r = (ra < rb) ? 32'd1 : 32'd0;
         4'd12: begin
            wide = {32'b0, ra} * {32'b0, rb};
            r    = wide[31:0];
            lat  = 33;
         end
         default: r = '0;
      endcase
      f = {(r == 32'd0), r[31], c, v};
   endfunction

   // Model state: an op in flight, a presented result, and the held result.
   logic        m_busy = 1'b0;
   logic        m_valid = 1'b0;
   int          m_left = 0;
   logic [31:0] m_y = '0;
   logic [3:0]  m_f = '0;
   logic [31:0] p_y = '0;
   logic [3:0]  p_f = '0;
   logic        e_rdy;
   logic        e_acc;
   logic [31:0] r_y;
   logic [3:0]  r_f;
   int          r_lat;

   // Compare DUT to model every cycle, then advance the model across the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_left  = 0;
      end else begin
         e_rdy = (!m_busy && !m_valid) || (m_valid && out_ready);
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("busy", 32'(busy), 32'(m_busy || m_valid));
         check("in_ready", 32'(in_ready), 32'(e_rdy));
         if (m_valid) begin
            check("y", y, m_y);
            check("flags", 32'({zero, neg, carry, ovf}), 32'(m_f));
         end
         e_acc = in_valid && e_rdy;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy  = 1'b0;
               m_valid = 1'b1;
               m_y     = p_y;
               m_f     = p_f;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (e_acc) begin
            model(select, a, b, r_y, r_f, r_lat);
            if (r_lat == 1) begin
               m_valid = 1'b1;
               m_y     = r_y;
               m_f     = r_f;
            end else begin
               m_busy  = 1'b1;
               m_valid = 1'b0;
               m_left  = r_lat - 1;
               p_y     = r_y;
               p_f     = r_f;
            end
         end
      end
   end

   // Sole driver of out_ready: random backpressure or the directed level.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_dir;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an op (caller sits just after a rising edge) and wait for its accept edge.
   task automatic run_op(input logic [3:0] sel, input logic [31:0] ra,
                         input logic [31:0] rb, output int waits);
      logic ok;
      in_valid = 1'b1;
      select   = sel;
      a        = ra;
      b        = rb;
      waits    = 0;
      ok       = 1'b0;
      while (!ok && waits < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      if (!ok) check("accept_timeout", 32'(waits), 32'd0);
      in_valid = 1'b0;
      select   = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   // Wait (bounded) for out_valid after an accept and pin latency, y and flags to literals.
   task automatic expect_res(input string name, input logic [31:0] ey,
                             input logic [3:0] ef, input int elat);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      check({name, "_lat"}, 32'(lat), 32'(elat));
      check({name, "_y"}, y, ey);
      check({name, "_flags"}, 32'({zero, neg, carry, ovf}), 32'(ef));
   endtask

   initial begin
      int w;
      int gap;
      logic [3:0]  rs;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      select   = '0;
      a        = '0;
      b        = '0;
      #3;
      check("rst_y", y, 32'd0);
      check("rst_flags", 32'({zero, neg, carry, ovf}), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Literal cases; flags are {zero,neg,carry,ovf}.
      run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, w);
      expect_res("add_ovf", 32'h8000_0000, 4'b0101, 1);
      tick();
      run_op(4'b1000, 32'd5, 32'd5, w);
      expect_res("sub_eq", 32'h0, 4'b1010, 1);
      tick();
      run_op(4'b1000, 32'd3, 32'd5, w);
      expect_res("sub_borrow", 32'hFFFF_FFFE, 4'b0100, 1);
      tick();
      run_op(4'b1001, 32'h8000_0010, 32'h24, w);
      expect_res("sra4", 32'hF800_0001, 4'b0100, 5);
      tick();
      run_op(4'b0101, 32'h8000_0001, 32'h20, w);
      expect_res("shl0", 32'h8000_0001, 4'b0100, 1);
      tick();
      run_op(4'b0101, 32'h8000_0001, 32'h1, w);
      expect_res("shl1", 32'h0000_0002, 4'b0010, 2);
      tick();
      run_op(4'b1010, 32'hFFFF_FFFF, 32'h1, w);
      expect_res("slt", 32'h1, 4'b0000, 1);
      tick();
      run_op(4'b1011, 32'hFFFF_FFFF, 32'h1, w);
      expect_res("sltu", 32'h0, 4'b1000, 1);
      tick();
      run_op(4'b1110, 32'h1234_5678, 32'h9, w);
      expect_res("op1110", 32'h0, 4'b1000, 1);
      tick();
      run_op(4'b1100, 32'h0001_0001, 32'h0001_0001, w);
      expect_res("mul", 32'h0002_0001, 4'b0000, 33);

      // Backpressure, then a same-edge back-to-back accept.
      rdy_dir = 1'b0;
      tick();
      run_op(4'b0000, 32'hF0, 32'h0F, w);
      expect_res("or_bp", 32'hFF, 4'b0000, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_y", y, 32'hFF);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      rdy_dir = 1'b1;
      tick();
      run_op(4'b0011, 32'hFF, 32'hFF, w);
      check("b2b_waits", 32'(w), 32'd1);
      expect_res("xor_b2b", 32'h0, 4'b1000, 1);

      // Reset in the middle of a multiply.
      tick();
      run_op(4'b1100, 32'hDEAD_BEEF, 32'h1234_5677, w);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_y", y, 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_flags", 32'({zero, neg, carry, ovf}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mrst_idle_busy", 32'(busy), 32'd0);
      check("mrst_idle_ready", 32'(in_ready), 32'd1);

      // Randomized traffic with random backpressure and gaps.
      tick();
      rdy_rand = 1'b1;
      for (int k = 0; k < 250; k++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
         rs = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFF_FFFF;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: rb = 32'd1;
            2: rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
         run_op(rs, ra, rb, w);
      end
      rdy_rand = 1'b0;
      rdy_dir  = 1'b1;
      repeat (40) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
